// File: rtl/hssl_apb_initiator_pkg.sv
//==============================================================================
// hssl_apb_initiator_pkg -- shared FSM encoding, reply constants and address helper. Rev 1.0
//==============================================================================
`default_nettype none

`ifndef REG_ADR_BITS
`define REG_ADR_BITS 12
`endif
`ifndef APB_ADR_BITS
`define APB_ADR_BITS 16
`endif
`ifndef BAD_REG
`define BAD_REG 32'hBAD0_0BAD
`endif

package hssl_apb_initiator_pkg;

  localparam int unsigned APB_TIMEOUT_DEF = 256;
  localparam int unsigned RPL_ERR_BIT     = 0;

  typedef logic [1:0] apb_state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_REPLY  = 2'd3;

  // Register word address to APB byte address; the slave strips the two LSBs again.
  function automatic logic [`APB_ADR_BITS-1:0] word_to_byte(input logic [`REG_ADR_BITS-1:0] a);
    logic [`REG_ADR_BITS+1:0] b;
    b = {a, 2'b00};
    return `APB_ADR_BITS'(b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hssl_apb_watchdog.sv
//==============================================================================
// hssl_apb_watchdog -- ACCESS-phase pready timeout counter (used under HSSL_APB_TIMEOUT_EN). Rev 1.0
//==============================================================================
`default_nettype none

module hssl_apb_watchdog
  import hssl_apb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_in,
  input  logic run_in,
  input  logic pready_in,
  output logic expired_out
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_in) begin
      cnt_d = '0;
    end else if (run_in && !pready_in && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_out = run_in && !pready_in && (cnt_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/hssl_apb_initiator.sv
//==============================================================================
// hssl_apb_initiator -- APB master turning register commands into APB transfers and reply packets.
// Optional ACCESS timeout: HSSL_APB_TIMEOUT_EN. Rev 1.0
//==============================================================================
`default_nettype none

module hssl_apb_initiator
  import hssl_apb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [`REG_ADR_BITS-1:0] cmd_addr_in,
  input  logic [31:0]              cmd_wdata_in,
  input  logic                     cmd_write_in,
  input  logic                     cmd_vld_in,
  output logic                     cmd_rdy_out,
  input  logic [31:0]              reply_key_in,
  output logic                     apb_psel_out,
  output logic                     apb_penable_out,
  output logic                     apb_pwrite_out,
  output logic [`APB_ADR_BITS-1:0] apb_paddr_out,
  output logic [31:0]              apb_pwdata_out,
  input  logic [31:0]              apb_prdata_in,
  input  logic                     apb_pready_in,
  input  logic                     apb_pslverr_in,
  output logic [31:0]              rpl_key_out,
  output logic [31:0]              rpl_data_out,
  output logic                     rpl_vld_out,
  input  logic                     rpl_rdy_in,
  output logic                     busy_out
);

  apb_state_t               state_q,   state_d;
  logic                     psel_q,    psel_d;
  logic                     penable_q, penable_d;
  logic                     pwrite_q,  pwrite_d;
  logic [`APB_ADR_BITS-1:0] paddr_q,   paddr_d;
  logic [31:0]              pwdata_q,  pwdata_d;
  logic [31:0]              rpl_key_q, rpl_key_d;
  logic [31:0]              rpl_data_q, rpl_data_d;
  logic                     rpl_vld_q, rpl_vld_d;
  logic                     timeout;

`ifdef HSSL_APB_TIMEOUT_EN
  hssl_apb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .resetn      (resetn),
    .clear_in    (state_q == ST_SETUP),
    .run_in      (state_q == ST_ACCESS),
    .pready_in   (apb_pready_in),
    .expired_out (timeout)
  );
`else
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    rpl_key_d  = rpl_key_q;
    rpl_data_d = rpl_data_q;
    rpl_vld_d  = rpl_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_vld_in) begin
          state_d  = ST_SETUP;
          psel_d   = 1'b1;
          paddr_d  = word_to_byte(cmd_addr_in);
          pwrite_d = cmd_write_in;
          pwdata_d = cmd_wdata_in;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (apb_pready_in || timeout) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          pwdata_d  = '0;
          state_d   = ST_IDLE;
          // pwrite_q/pwdata_q still hold the command on this edge
          if (!apb_pready_in) begin
            state_d                = ST_REPLY;
            rpl_vld_d              = 1'b1;
            rpl_key_d              = reply_key_in;
            rpl_key_d[RPL_ERR_BIT] = 1'b1;
            rpl_data_d             = `BAD_REG;
          end else if (!pwrite_q || apb_pslverr_in) begin
            state_d                = ST_REPLY;
            rpl_vld_d              = 1'b1;
            rpl_key_d              = reply_key_in;
            rpl_key_d[RPL_ERR_BIT] = apb_pslverr_in;
            rpl_data_d             = pwrite_q ? pwdata_q : apb_prdata_in;
          end
        end
      end
      ST_REPLY: begin
        if (rpl_rdy_in) begin
          rpl_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      rpl_key_q  <= '0;
      rpl_data_q <= '0;
      rpl_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      rpl_key_q  <= rpl_key_d;
      rpl_data_q <= rpl_data_d;
      rpl_vld_q  <= rpl_vld_d;
    end
  end

  assign cmd_rdy_out     = (state_q == ST_IDLE);
  assign busy_out        = (state_q != ST_IDLE);
  assign apb_psel_out    = psel_q;
  assign apb_penable_out = penable_q;
  assign apb_pwrite_out  = pwrite_q;
  assign apb_paddr_out   = paddr_q;
  assign apb_pwdata_out  = pwdata_q;
  assign rpl_key_out     = rpl_key_q;
  assign rpl_data_out    = rpl_data_q;
  assign rpl_vld_out     = rpl_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_hssl_apb_initiator.sv
// tb_hssl_apb_initiator -- scoreboard bench: APB slave model, expected replies queued per command.
`default_nettype none

`ifndef REG_ADR_BITS
`define REG_ADR_BITS 12
`endif
`ifndef APB_ADR_BITS
`define APB_ADR_BITS 16
`endif
`ifndef BAD_REG
`define BAD_REG 32'hBAD0_0BAD
`endif

module tb_hssl_apb_initiator;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [`REG_ADR_BITS-1:0] cmd_addr_in;
  logic [31:0]              cmd_wdata_in;
  logic                     cmd_write_in;
  logic                     cmd_vld_in;
  logic                     cmd_rdy_out;
  logic [31:0]              reply_key_in;
  logic                     apb_psel_out;
  logic                     apb_penable_out;
  logic                     apb_pwrite_out;
  logic [`APB_ADR_BITS-1:0] apb_paddr_out;
  logic [31:0]              apb_pwdata_out;
  logic [31:0]              apb_prdata_in;
  logic                     apb_pready_in;
  logic                     apb_pslverr_in;
  logic [31:0]              rpl_key_out;
  logic [31:0]              rpl_data_out;
  logic                     rpl_vld_out;
  logic                     rpl_rdy_in;
  logic                     busy_out;

  typedef struct packed {
    logic [31:0] key;
    logic [31:0] data;
  } rpl_t;

  rpl_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // slave model controls
  int          slv_wait  = 0;
  bit          slv_err   = 1'b0;
  bit          slv_stuck = 1'b0;
  logic [31:0] slv_rdata = '0;

  hssl_apb_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .cmd_addr_in     (cmd_addr_in),
    .cmd_wdata_in    (cmd_wdata_in),
    .cmd_write_in    (cmd_write_in),
    .cmd_vld_in      (cmd_vld_in),
    .cmd_rdy_out     (cmd_rdy_out),
    .reply_key_in    (reply_key_in),
    .apb_psel_out    (apb_psel_out),
    .apb_penable_out (apb_penable_out),
    .apb_pwrite_out  (apb_pwrite_out),
    .apb_paddr_out   (apb_paddr_out),
    .apb_pwdata_out  (apb_pwdata_out),
    .apb_prdata_in   (apb_prdata_in),
    .apb_pready_in   (apb_pready_in),
    .apb_pslverr_in  (apb_pslverr_in),
    .rpl_key_out     (rpl_key_out),
    .rpl_data_out    (rpl_data_out),
    .rpl_vld_out     (rpl_vld_out),
    .rpl_rdy_in      (rpl_rdy_in),
    .busy_out        (busy_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // APB slave: pready after slv_wait ACCESS cycles, driven on the falling edge
  initial begin
    int  acc_cnt;
    bit  rdy;
    acc_cnt        = 0;
    apb_pready_in  = 1'b0;
    apb_pslverr_in = 1'b0;
    apb_prdata_in  = '0;
    forever begin
      @(negedge clk);
      if (apb_psel_out && apb_penable_out) begin
        rdy = !slv_stuck && (acc_cnt >= slv_wait);
        acc_cnt++;
      end else begin
        rdy     = 1'b0;
        acc_cnt = 0;
      end
      apb_pready_in  = rdy;
      apb_pslverr_in = rdy & slv_err;
      apb_prdata_in  = rdy ? slv_rdata : 32'h0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, failures=%0d", failures);
    $fatal(1, "global timeout");
  end

  task automatic send_cmd(input logic [`REG_ADR_BITS-1:0] a, input logic [31:0] wd,
                          input logic wr, output bit ok);
    int n;
    @(negedge clk);
    cmd_addr_in  = a;
    cmd_wdata_in = wd;
    cmd_write_in = wr;
    cmd_vld_in   = 1'b1;
    n = 0;
    while (!cmd_rdy_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    cmd_vld_in = 1'b0;
    ok = (n < 200);
  endtask

  // cycles until rpl_vld is seen (sampled 1ns after each edge), -1 if never
  task automatic wait_rpl(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (rpl_vld_out) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    cmd_vld_in   = 1'b0;
    cmd_addr_in  = '0;
    cmd_wdata_in = '0;
    cmd_write_in = 1'b0;
    reply_key_in = 32'hffff_fd00;
    rpl_rdy_in   = 1'b1;
    resetn       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({apb_psel_out, apb_penable_out, apb_pwrite_out, rpl_vld_out, busy_out} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {apb_psel_out, apb_penable_out, apb_pwrite_out, rpl_vld_out, busy_out});
    end
    checks++;
    if (cmd_rdy_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_rdy: got %b expected 1", cmd_rdy_out);
    end
    checks++;
    if ({apb_paddr_out, apb_pwdata_out, rpl_key_out, rpl_data_out} !== '0) begin
      failures++;
      $display("FAIL reset_data: paddr=%h pwdata=%h key=%h data=%h expected all 0", apb_paddr_out, apb_pwdata_out, rpl_key_out, rpl_data_out);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_read;
    bit   ok;
    int   n;
    rpl_t e;
    slv_wait  = 0;
    slv_err   = 1'b0;
    slv_rdata = 32'h1234_5678;
    exp_q.push_back('{key: 32'hffff_fd00, data: 32'h1234_5678});
    send_cmd(12'h00F, 32'h0, 1'b0, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL read_accept: got no accept expected accept");
    end
    checks++;
    if ({apb_psel_out, apb_penable_out, apb_pwrite_out} !== 3'b100 || apb_paddr_out !== 16'h003C) begin
      failures++;
      $display("FAIL read_setup: got sel/en/wr=%b paddr=%h expected 100 003c", {apb_psel_out, apb_penable_out, apb_pwrite_out}, apb_paddr_out);
    end
    wait_rpl(20, n);
    checks++;
    if (n + 1 !== 3) begin
      failures++;
      $display("FAIL read_latency: got %0d expected 3", n + 1);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL read_scoreboard: got empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
      if (rpl_key_out !== e.key || rpl_data_out !== e.data) begin
        failures++;
        $display("FAIL read_reply: got key=%h data=%h expected key=%h data=%h", rpl_key_out, rpl_data_out, e.key, e.data);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (rpl_vld_out !== 1'b0 || cmd_rdy_out !== 1'b1) begin
      failures++;
      $display("FAIL read_done: got vld=%b rdy=%b expected 0 1", rpl_vld_out, cmd_rdy_out);
    end
  endtask

  task automatic test_write_wait;
    bit ok;
    int sel_n, en_n, rdy_at;
    bit saw_rpl;
    slv_wait = 4;
    send_cmd(12'h042, 32'h0000_0020, 1'b1, ok);
    checks++;
    if (!ok || apb_pwrite_out !== 1'b1 || apb_pwdata_out !== 32'h20 || apb_paddr_out !== 16'h0108) begin
      failures++;
      $display("FAIL wr_setup: got ok=%b wr=%b wd=%h paddr=%h expected 1 1 00000020 0108", ok, apb_pwrite_out, apb_pwdata_out, apb_paddr_out);
    end
    sel_n = 0; en_n = 0; rdy_at = -1; saw_rpl = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      sel_n += int'(apb_psel_out);
      en_n  += int'(apb_penable_out);
      if (rpl_vld_out) saw_rpl = 1'b1;
      if (cmd_rdy_out && rdy_at < 0) rdy_at = i;
    end
    checks++;
    if (sel_n !== 6 || en_n !== 5) begin
      failures++;
      $display("FAIL wr_wait_len: got psel=%0d penable=%0d expected 6 5", sel_n, en_n);
    end
    checks++;
    if (rdy_at !== 6 || saw_rpl !== 1'b0) begin
      failures++;
      $display("FAIL wr_wait_done: got rdy_at=%0d reply=%b expected 6 0", rdy_at, saw_rpl);
    end
    checks++;
    if (apb_pwrite_out !== 1'b0 || apb_pwdata_out !== 32'h0 || apb_paddr_out !== 16'h0108) begin
      failures++;
      $display("FAIL wr_idle_outs: got wr=%b wd=%h paddr=%h expected 0 00000000 0108", apb_pwrite_out, apb_pwdata_out, apb_paddr_out);
    end
    slv_wait = 0;
  endtask

  task automatic test_write_err;
    bit   ok;
    int   n;
    rpl_t e;
    slv_wait = 1;
    slv_err  = 1'b1;
    exp_q.push_back('{key: 32'hffff_fd01, data: 32'h0000_0020});
    send_cmd(12'h042, 32'h0000_0020, 1'b1, ok);
    wait_rpl(20, n);
    checks++;
    if (!ok || n < 0 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL werr_reply_seen: got ok=%b n=%0d expected reply", ok, n);
    end else begin
      e = exp_q.pop_front();
      if (rpl_key_out !== e.key || rpl_data_out !== e.data) begin
        failures++;
        $display("FAIL werr_reply: got key=%h data=%h expected key=%h data=%h", rpl_key_out, rpl_data_out, e.key, e.data);
      end
    end
    slv_err  = 1'b0;
    slv_wait = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    bit ok0, ok1, ok2;
    int t0, t1, t2;
    send_cmd(12'h010, 32'h1111_0000, 1'b1, ok0); t0 = cyc;
    send_cmd(12'h011, 32'h2222_0000, 1'b1, ok1); t1 = cyc;
    send_cmd(12'h012, 32'h3333_0000, 1'b1, ok2); t2 = cyc;
    checks++;
    if (!(ok0 && ok1 && ok2) || (t1 - t0) !== 3 || (t2 - t1) !== 3) begin
      failures++;
      $display("FAIL b2b_rate: got gaps %0d %0d expected 3 3", t1 - t0, t2 - t1);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rpl_vld_out !== 1'b0 || cmd_rdy_out !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle: got vld=%b rdy=%b expected 0 1", rpl_vld_out, cmd_rdy_out);
    end
  endtask

  task automatic test_backpressure;
    bit   ok;
    int   n, bad;
    rpl_t e;
    rpl_rdy_in   = 1'b0;
    slv_rdata    = 32'hAABB_CCDD;
    reply_key_in = 32'h1234_5600;
    exp_q.push_back('{key: 32'h1234_5600, data: 32'hAABB_CCDD});
    send_cmd(12'h007, 32'h0, 1'b0, ok);
    wait_rpl(20, n);
    e = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    reply_key_in = 32'h0;
    cmd_addr_in  = 12'h005;
    cmd_wdata_in = 32'h99;
    cmd_write_in = 1'b1;
    cmd_vld_in   = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rpl_vld_out !== 1'b1 || rpl_key_out !== e.key || rpl_data_out !== e.data ||
          cmd_rdy_out !== 1'b0 || busy_out !== 1'b1)
        bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n < 0 || bad !== 0) begin
      failures++;
      $display("FAIL bp_hold: got n=%0d unstable=%0d key=%h data=%h expected key=%h data=%h", n, bad, rpl_key_out, rpl_data_out, e.key, e.data);
    end
    @(negedge clk);
    rpl_rdy_in = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rpl_vld_out !== 1'b0 || cmd_rdy_out !== 1'b1 || apb_psel_out !== 1'b0) begin
      failures++;
      $display("FAIL bp_handshake: got vld=%b rdy=%b psel=%b expected 0 1 0", rpl_vld_out, cmd_rdy_out, apb_psel_out);
    end
    @(posedge clk);
    #1;
    cmd_vld_in = 1'b0;
    checks++;
    if (apb_psel_out !== 1'b1 || apb_paddr_out !== 16'h0014) begin
      failures++;
      $display("FAIL bp_next_cmd: got psel=%b paddr=%h expected 1 0014", apb_psel_out, apb_paddr_out);
    end
    repeat (3) @(posedge clk);
    #1;
    reply_key_in = 32'hffff_fd00;
  endtask

  task automatic test_reset_mid_access;
    bit ok;
    int n;
    bit saw_rpl;
    slv_wait = 50;
    send_cmd(12'h001, 32'h0, 1'b0, ok);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if (apb_psel_out !== 1'b0 || apb_penable_out !== 1'b0 || cmd_rdy_out !== 1'b1 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got sel=%b en=%b rdy=%b busy=%b expected 0 0 1 0", apb_psel_out, apb_penable_out, cmd_rdy_out, busy_out);
    end
    @(posedge clk);
    @(negedge clk);
    resetn   = 1'b1;
    slv_wait = 0;
    saw_rpl  = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (rpl_vld_out || busy_out) saw_rpl = 1'b1;
    end
    checks++;
    if (saw_rpl !== 1'b0 || cmd_rdy_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_no_reply: got activity=%b rdy=%b expected 0 1", saw_rpl, cmd_rdy_out);
    end
  endtask

  task automatic test_timeout;
    bit   ok;
    int   n;
    rpl_t e;
    slv_stuck = 1'b1;
`ifdef HSSL_APB_TIMEOUT_EN
    exp_q.push_back('{key: 32'hffff_fd01, data: `BAD_REG});
    send_cmd(12'h020, 32'h0, 1'b0, ok);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!apb_penable_out) break;
      n++;
    end
    checks++;
    if (!ok || n !== 8 || rpl_vld_out !== 1'b1) begin
      failures++;
      $display("FAIL tmo_abort: got access_cycles=%0d vld=%b expected 8 1", n, rpl_vld_out);
    end
`else
    exp_q.push_back('{key: 32'hffff_fd00, data: 32'h5555_AAAA});
    slv_rdata = 32'h5555_AAAA;
    send_cmd(12'h020, 32'h0, 1'b0, ok);
    wait_rpl(1000, n);
    checks++;
    if (!ok || n !== -1 || apb_penable_out !== 1'b1 || busy_out !== 1'b1) begin
      failures++;
      $display("FAIL no_tmo_wait: got n=%0d en=%b busy=%b expected -1 1 1", n, apb_penable_out, busy_out);
    end
    slv_stuck = 1'b0;
    wait_rpl(10, n);
`endif
    checks++;
    if (exp_q.size() == 0 || !rpl_vld_out) begin
      failures++;
      $display("FAIL tmo_reply_seen: got vld=%b expected 1", rpl_vld_out);
    end else begin
      e = exp_q.pop_front();
      if (rpl_key_out !== e.key || rpl_data_out !== e.data) begin
        failures++;
        $display("FAIL tmo_reply: got key=%h data=%h expected key=%h data=%h", rpl_key_out, rpl_data_out, e.key, e.data);
      end
    end
    slv_stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_write_err();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_access();
    test_timeout();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
